// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution controller:
// op kinds, branch funct3 codes, FSM states and history-table counters.
package branch_pkg;

    typedef enum logic [1:0] {
        KIND_NOP    = 2'b00,
        KIND_BRANCH = 2'b01,
        KIND_JAL    = 2'b10,
        KIND_JALR   = 2'b11
    } kind_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef logic [1:0] bht_ctr_t;

    // Weakly not-taken.
    localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

    // Saturating 2-bit counter step towards the resolved direction.
    function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        if (taken) begin
            if (ctr == 2'b11) nxt = ctr;
            else              nxt = ctr + 2'b01;
        end else begin
            if (ctr == 2'b00) nxt = ctr;
            else              nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator (RV32I funct3 encodings).
// Reserved funct3 codes 010/011 are never taken.
module br_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            taken_o
);

    logic eq_s;
    logic lt_s;
    logic ltu_s;

    assign eq_s  = (src1_i == src2_i);
    assign lt_s  = ($signed(src1_i) < $signed(src2_i));
    assign ltu_s = (src1_i < src2_i);

    // Select the comparison result for the requested branch type.
    always_comb begin
        taken_o = 1'b0;
        case (funct_i)
            F3_BEQ:  taken_o = eq_s;
            F3_BNE:  taken_o = ~eq_s;
            F3_BLT:  taken_o = lt_s;
            F3_BGE:  taken_o = ~lt_s;
            F3_BLTU: taken_o = ltu_s;
            F3_BGEU: taken_o = ~ltu_s;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl_chk.sv
// Assertion checker for branch_ctrl: configuration legality and
// mutual exclusion of the control strobes.
module branch_ctrl_chk #(
    parameter int FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic rst_n,
    input logic flush_i,
    input logic in_ready_i,
    input logic redirect_i,
    input logic out_valid_i,
    input logic out_exc_i
);

    // Sample the invariants on every active cycle outside reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (FLUSH_CYCLES >= 1)
                else $error("branch_ctrl: FLUSH_CYCLES must be at least 1");
            assert (!(flush_i && in_ready_i))
                else $error("branch_ctrl: issue ready while flushing");
            assert (!(redirect_i && out_exc_i))
                else $error("branch_ctrl: redirect together with exception");
            assert (!redirect_i || out_valid_i)
                else $error("branch_ctrl: redirect without resolution strobe");
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution controller between issue and fetch.
// Resolves one control-transfer op per cycle (result one cycle later),
// raises redirect on mispredict or out_exc on a misaligned target, and
// holds flush for FLUSH_CYCLES cycles while issue is stalled.
// Optional feature macro: BRANCH_CTRL_BHT_EN adds a 2-bit-counter BHT
// that drives fetch_pred_taken; without it fetch_pred_taken is 0.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_ENTRIES  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_kind,
    input  logic [2:0]      in_funct,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            out_valid,
    output logic            out_taken,
    output logic [XLEN-1:0] out_link,
    output logic            out_exc,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_pred_taken
);

    // Counter holds the number of flush cycles still to come after the current one.
    localparam int               CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_taken_q, out_exc_q, redirect_q;
    logic [XLEN-1:0]   out_link_q, redirect_pc_q;

    kind_e             kind_s;
    logic              accept_s, is_op_s, cond_taken_s;
    logic              taken_s, mispred_s, exc_s, redir_s;
    logic [XLEN-1:0]   target_s, link_s, next_pc_s;

    assign kind_s   = kind_e'(in_kind);
    assign accept_s = in_valid & in_ready_q;

    br_cond_eval #(.XLEN(XLEN)) u_cond (
        .funct_i (in_funct),
        .src1_i  (in_src1),
        .src2_i  (in_src2),
        .taken_o (cond_taken_s)
    );

    // Resolve direction, target and mispredict for the op offered this cycle.
    always_comb begin
        taken_s  = 1'b0;
        target_s = in_pc + in_imm;
        case (kind_s)
            KIND_BRANCH: taken_s = cond_taken_s;
            KIND_JAL:    taken_s = 1'b1;
            KIND_JALR: begin
                taken_s  = 1'b1;
                target_s = (in_src1 + in_imm) & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default:     taken_s = 1'b0;
        endcase
        link_s    = in_pc + XLEN'(4);
        next_pc_s = taken_s ? target_s : link_s;
        mispred_s = (taken_s != in_pred_taken) | (taken_s & (target_s != in_pred_target));
        is_op_s   = accept_s & (kind_s != KIND_NOP);
        // A misaligned taken target wins over a redirect.
        exc_s     = is_op_s & taken_s & target_s[1];
        redir_s   = is_op_s & ~exc_s & mispred_s;
    end

    // RUN/FLUSH next-state and flush countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redir_s | exc_s) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LAST;
                    flush_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            ST_FLUSH: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        in_ready_d = (state_d == ST_RUN);
    end

    // State, flush and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            cnt_q         <= {CNT_W{1'b0}};
            flush_q       <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_taken_q   <= 1'b0;
            out_exc_q     <= 1'b0;
            redirect_q    <= 1'b0;
            out_link_q    <= {XLEN{1'b0}};
            redirect_pc_q <= {XLEN{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flush_q       <= flush_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= is_op_s;
            out_taken_q   <= is_op_s & taken_s;
            out_exc_q     <= exc_s;
            redirect_q    <= redir_s;
            out_link_q    <= is_op_s ? link_s : {XLEN{1'b0}};
            redirect_pc_q <= redir_s ? next_pc_s : {XLEN{1'b0}};
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_taken   = out_taken_q;
    assign out_exc     = out_exc_q;
    assign out_link    = out_link_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush       = flush_q;

`ifdef BRANCH_CTRL_BHT_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t         bht_q [BHT_ENTRIES];
    logic             upd_br_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic [XLEN-1:0]  fetch_pc_unused_s;

    // Remember whether the op being resolved is a conditional branch and its index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_br_q  <= 1'b0;
            upd_idx_q <= {IDX_W{1'b0}};
        end else begin
            upd_br_q  <= is_op_s & (kind_s == KIND_BRANCH);
            upd_idx_q <= in_pc[IDX_W+1:2];
        end
    end

    // Train the counter in the resolution cycle; lookups see the pre-update value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= BHT_CTR_RESET;
            end
        end else if (out_valid_q & upd_br_q) begin
            bht_q[upd_idx_q] <= bht_ctr_next(bht_q[upd_idx_q], out_taken_q);
        end
    end

    assign fetch_pred_taken  = bht_q[fetch_pc[IDX_W+1:2]][1];
    assign fetch_pc_unused_s = fetch_pc;
`else
    logic [XLEN-1:0] fetch_pc_unused_s;

    assign fetch_pred_taken  = 1'b0;
    assign fetch_pc_unused_s = fetch_pc;
`endif

    branch_ctrl_chk #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_q),
        .in_ready_i  (in_ready_q),
        .redirect_i  (redirect_q),
        .out_valid_i (out_valid_q),
        .out_exc_i   (out_exc_q)
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus a randomized
// run compared against a behavioural model of the resolution rules.
module tb_branch_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_pred_taken;
    logic [1:0]  in_kind;
    logic [2:0]  in_funct;
    logic [31:0] in_pc, in_imm, in_src1, in_src2, in_pred_target, fetch_pc;
    logic        out_valid, out_taken, out_exc, redirect, flush, fetch_pred_taken;
    logic [31:0] out_link, redirect_pc;

    int errors = 0;
    int checks = 0;

    // Model outputs
    logic        e_valid, e_taken, e_exc, e_redir, e_flush;
    logic [31:0] e_link, e_rpc, e_tgt;

    always #5 clk = ~clk;

    branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .BHT_ENTRIES(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct(in_funct), .in_pc(in_pc), .in_imm(in_imm),
        .in_src1(in_src1), .in_src2(in_src2), .in_pred_taken(in_pred_taken),
        .in_pred_target(in_pred_target), .out_valid(out_valid), .out_taken(out_taken),
        .out_link(out_link), .out_exc(out_exc), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .fetch_pc(fetch_pc),
        .fetch_pred_taken(fetch_pred_taken)
    );

    // Reference model: architectural meaning of one control-transfer op.
    function automatic void model(input logic [1:0] k, input logic [2:0] f,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [31:0] s1, input logic [31:0] s2,
                                  input logic pt, input logic [31:0] ptgt);
        logic tk;
        logic mis;
        tk = 1'b0;
        if (k == 2'd1) begin
            case (f)
                3'b000:  tk = (s1 == s2);
                3'b001:  tk = (s1 != s2);
                3'b100:  tk = ($signed(s1) <  $signed(s2));
                3'b101:  tk = ($signed(s1) >= $signed(s2));
                3'b110:  tk = (s1 <  s2);
                3'b111:  tk = (s1 >= s2);
                default: tk = 1'b0;
            endcase
        end else if (k != 2'd0) begin
            tk = 1'b1;
        end
        e_tgt   = (k == 2'd3) ? ((s1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        e_rpc   = tk ? e_tgt : pc + 32'd4;
        mis     = (tk != pt) || (tk && (e_tgt != ptgt));
        e_valid = (k != 2'd0);
        e_taken = tk;
        e_link  = pc + 32'd4;
        e_exc   = e_valid && tk && e_tgt[1];
        e_redir = e_valid && !e_exc && mis;
        e_flush = e_exc || e_redir;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_kind  = 2'b00;
    endtask

    task automatic set_op(input logic [1:0] k, input logic [2:0] f, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] s1, input logic [31:0] s2,
                          input logic pt, input logic [31:0] ptgt);
        in_valid = 1'b1; in_kind = k; in_funct = f; in_pc = pc; in_imm = imm;
        in_src1 = s1; in_src2 = s2; in_pred_taken = pt; in_pred_target = ptgt;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: in_ready=%b required 1 within 20 cycles", in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        checks++;
        if ({in_ready, out_valid, out_taken, out_exc, redirect, flush} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_flags: rdy/ov/tk/exc/red/fl=%b required 000000",
                     {in_ready, out_valid, out_taken, out_exc, redirect, flush});
        end
        checks++;
        if (out_link !== 32'h0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: link=%h rpc=%h required 0/0", out_link, redirect_pc);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_bht();
`ifdef BRANCH_CTRL_BHT_EN
        fetch_pc = 32'h40;
        #1;
        checks++;
        if (fetch_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL bht_init: pred=%b required 0", fetch_pred_taken);
        end
        for (int i = 0; i < 2; i++) begin
            wait_ready();
            set_op(2'b01, 3'b000, 32'h40, 32'h10, 32'd7, 32'd7, 1'b1, 32'h50);
            step();
            idle();
            step();
        end
        checks++;
        if (fetch_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL bht_taken2: pred=%b required 1", fetch_pred_taken);
        end
        fetch_pc = 32'h44;
        #1;
        checks++;
        if (fetch_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL bht_other_idx: pred=%b required 0", fetch_pred_taken);
        end
        fetch_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            set_op(2'b01, 3'b001, 32'h40, 32'h10, 32'd7, 32'd7, 1'b0, 32'h0);
            step();
            idle();
            step();
            // Counter walks 11 -> 10 -> 01 -> 00
            checks++;
            if (fetch_pred_taken !== (i == 0)) begin
                errors++;
                $display("FAIL bht_nt%0d: pred=%b required %b", i + 1, fetch_pred_taken, (i == 0));
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            fetch_pc = $urandom;
            #1;
            checks++;
            if (fetch_pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL bht_off: pc=%h pred=%b required 0", fetch_pc, fetch_pred_taken);
            end
        end
`endif
    endtask

    task automatic test_beq_redirect();
        wait_ready();
        set_op(2'b01, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0);
        step();
        idle();
        checks++;
        if ({out_valid, out_taken, out_exc, redirect, flush, in_ready} !== 6'b110110) begin
            errors++;
            $display("FAIL beq_flags: ov/tk/exc/red/fl/rdy=%b required 110110",
                     {out_valid, out_taken, out_exc, redirect, flush, in_ready});
        end
        checks++;
        if (redirect_pc !== 32'h120 || out_link !== 32'h104) begin
            errors++;
            $display("FAIL beq_data: rpc=%h link=%h required 120/104", redirect_pc, out_link);
        end
        step();
        checks++;
        if ({out_valid, redirect, flush, in_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL beq_flush2: ov/red/fl/rdy=%b required 0010",
                     {out_valid, redirect, flush, in_ready});
        end
        step();
        checks++;
        if ({flush, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL beq_flush_end: fl/rdy=%b required 01", {flush, in_ready});
        end
    endtask

    task automatic test_signed_unsigned();
        logic [2:0]  ftab [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic        ttab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            set_op(2'b01, ftab[i], 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, ttab[i], 32'h340);
            step();
            idle();
            checks++;
            if ({out_valid, out_taken, out_exc, redirect, flush, in_ready} !== {1'b1, ttab[i], 4'b0001}) begin
                errors++;
                $display("FAIL cmp_f%b: ov/tk/exc/red/fl/rdy=%b required %b", ftab[i],
                         {out_valid, out_taken, out_exc, redirect, flush, in_ready}, {1'b1, ttab[i], 4'b0001});
            end
        end
    endtask

    task automatic test_jalr();
        wait_ready();
        // Target 0x1002 has bit 1 set: misaligned, so exception instead of redirect.
        set_op(2'b11, 3'b000, 32'h200, 32'h0, 32'h1003, 32'h0, 1'b1, 32'h1002);
        step();
        idle();
        checks++;
        if ({out_valid, out_taken, out_exc, redirect, flush, in_ready} !== 6'b111010 || out_link !== 32'h204) begin
            errors++;
            $display("FAIL jalr: ov/tk/exc/red/fl/rdy=%b link=%h required 111010/204",
                     {out_valid, out_taken, out_exc, redirect, flush, in_ready}, out_link);
        end
        for (int c = 1; c < FC; c++) step();
        step();
        checks++;
        if ({flush, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL jalr_flush_end: fl/rdy=%b required 01", {flush, in_ready});
        end
    endtask

    task automatic test_jal_exc();
        wait_ready();
        set_op(2'b10, 3'b000, 32'h100, 32'h6, 32'h0, 32'h0, 1'b1, 32'h106);
        step();
        idle();
        checks++;
        if ({out_valid, out_taken, out_exc, redirect, flush, in_ready} !== 6'b111010 || out_link !== 32'h104) begin
            errors++;
            $display("FAIL jal_exc: ov/tk/exc/red/fl/rdy=%b link=%h required 111010/104",
                     {out_valid, out_taken, out_exc, redirect, flush, in_ready}, out_link);
        end
        for (int c = 1; c < FC; c++) begin
            step();
            checks++;
            if ({flush, in_ready} !== 2'b10) begin
                errors++;
                $display("FAIL jal_flush_hold: fl/rdy=%b required 10", {flush, in_ready});
            end
        end
        step();
        checks++;
        if ({flush, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL jal_flush_end: fl/rdy=%b required 01", {flush, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ftab [4] = '{3'b000, 3'b001, 3'b100, 3'b111};
        logic [31:0] s1, s2, pc;
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            s1 = $urandom;
            s2 = (i % 2 == 1) ? s1 : $urandom;
            pc = 32'h400 + 32'(16 * i);
            model(2'b01, ftab[i], pc, 32'h80, s1, s2, 1'b0, 32'h0);
            set_op(2'b01, ftab[i], pc, 32'h80, s1, s2, e_taken, pc + 32'h80);
            step();
            checks++;
            if ({in_ready, out_valid, out_taken, redirect, flush} !== {2'b11, e_taken, 2'b00}) begin
                errors++;
                $display("FAIL b2b_%0d: rdy/ov/tk/red/fl=%b required %b", i,
                         {in_ready, out_valid, out_taken, redirect, flush}, {2'b11, e_taken, 2'b00});
            end
        end
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_flush();
        wait_ready();
        set_op(2'b01, 3'b000, 32'h500, 32'h40, 32'd1, 32'd1, 1'b0, 32'h0);
        step();
        idle();
        rst_n = 1'b0;
        step();
        checks++;
        if ({flush, redirect, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_flush: fl/red/rdy=%b required 000", {flush, redirect, in_ready});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({flush, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_release: fl/rdy=%b required 01", {flush, in_ready});
        end
    endtask

    task automatic test_random();
        logic [1:0]  k;
        logic [2:0]  f;
        logic [31:0] pc, imm, s1, s2, ptgt;
        logic        pt;
        int          nf;
        for (int n = 0; n < 150; n++) begin
            wait_ready();
            k   = 2'($urandom_range(0, 3));
            f   = 3'($urandom_range(0, 7));
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFE) : ($urandom & 32'hFFFF_FFFC);
            s1  = $urandom;
            s2  = ($urandom_range(0, 3) == 0) ? s1 : $urandom;
            model(k, f, pc, imm, s1, s2, 1'b0, 32'h0);
            pt   = ($urandom_range(0, 2) != 0) ? e_taken : ~e_taken;
            ptgt = ($urandom_range(0, 3) != 0) ? e_tgt : $urandom;
            model(k, f, pc, imm, s1, s2, pt, ptgt);
            set_op(k, f, pc, imm, s1, s2, pt, ptgt);
            step();
            idle();
            checks++;
            if (out_valid !== e_valid) begin
                errors++;
                $display("FAIL rnd%0d_valid: out_valid=%b required %b", n, out_valid, e_valid);
            end
            if (e_valid) begin
                checks++;
                if (out_taken !== e_taken || out_exc !== e_exc || out_link !== e_link) begin
                    errors++;
                    $display("FAIL rnd%0d_result: tk=%b exc=%b link=%h required %b/%b/%h",
                             n, out_taken, out_exc, out_link, e_taken, e_exc, e_link);
                end
            end
            checks++;
            if (redirect !== e_redir || flush !== e_flush) begin
                errors++;
                $display("FAIL rnd%0d_ctrl: red=%b fl=%b required %b/%b", n, redirect, flush, e_redir, e_flush);
            end
            if (e_redir) begin
                checks++;
                if (redirect_pc !== e_rpc) begin
                    errors++;
                    $display("FAIL rnd%0d_rpc: rpc=%h required %h", n, redirect_pc, e_rpc);
                end
            end
            // Offer junk jumps during the flush; none may be accepted.
            nf = 0;
            while (flush === 1'b1 && nf < 10) begin
                nf++;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd%0d_stall: in_ready=%b required 0", n, in_ready);
                end
                in_valid = 1'($urandom_range(0, 1));
                in_kind  = 2'b10;
                step();
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd%0d_ignored: out_valid=%b required 0", n, out_valid);
                end
            end
            idle();
            checks++;
            if (nf != (e_flush ? FC : 0) || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_flushlen: cycles=%0d rdy=%b required %0d/1",
                         n, nf, in_ready, e_flush ? FC : 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_kind = 2'b00; in_funct = 3'b000;
        in_pc = 32'h0; in_imm = 32'h0; in_src1 = 32'h0; in_src2 = 32'h0;
        in_pred_taken = 1'b0; in_pred_target = 32'h0; fetch_pc = 32'h0;
        test_reset();
        test_bht();
        test_beq_redirect();
        test_signed_unsigned();
        test_jalr();
        test_jal_exc();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
